// File: rtl/arbitro_escritura_br.sv
`timescale 1ns/1ps
// arbitro_escritura_br
// Round-robin arbiter that shares the register bank's single write port
// between two writeback requesters: requester 0 (ALU result) and
// requester 1 (load data). Each requester owns a one-entry holding buffer
// with a valid/ready handshake. At most one registered write is issued per
// cycle. A per-register pending mask lets issue logic stall on writes that
// are still buffered.
//
// Ports
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   reqK_valid          requester K presents a write
//   reqK_addr/reqK_data requester K destination register and data
//   reqK_ready          requester K buffer accepts this cycle
//   EnW, AW, DW         registered write port to the register bank
//   grant_id            requester whose write is on AW/DW while EnW=1
//   busy                bit a set while a buffered write targets register a
module arbitro_escritura_br #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic [ADDR_W-1:0]    req0_addr,
  input  logic [DATA_W-1:0]    req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ADDR_W-1:0]    req1_addr,
  input  logic [DATA_W-1:0]    req1_data,
  output logic                 req1_ready,
  output logic                 EnW,
  output logic [ADDR_W-1:0]    AW,
  output logic [DATA_W-1:0]    DW,
  output logic [2**ADDR_W-1:0] busy,
  output logic                 grant_id
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  logic [0:0]        state;
  logic              full0, full1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;
  logic              older1;  // buf1 was accepted before buf0 (valid when both full)
  logic              prio;    // requester favoured when both full, addresses differ
  logic              sel0, sel1;
  logic              kept0, kept1;
  logic              acc0, acc1;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    if (full0 && full1) begin
      // Same destination: oldest write first keeps cross-requester order.
      if (addr0 == addr1) sel0 = !older1;
      else                sel0 = !prio;
      sel1 = !sel0;
    end else begin
      sel0 = full0;
      sel1 = full1;
    end
    kept0 = full0 && !sel0;
    kept1 = full1 && !sel1;
  end

  // A buffer being drained this cycle can refill on the same edge.
  assign req0_ready = rst_n && (!full0 || sel0);
  assign req1_ready = rst_n && (!full1 || sel1);
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;

  assign EnW = (state == WRITE);

  always_comb begin
    busy = '0;
    if (rst_n) begin
      if (full0) busy[addr0] = 1'b1;
      if (full1) busy[addr1] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      full0    <= 1'b0;
      full1    <= 1'b0;
      older1   <= 1'b0;
      prio     <= 1'b0;
      AW       <= '0;
      DW       <= '0;
      grant_id <= 1'b0;
    end else begin
      full0 <= acc0 || kept0;
      full1 <= acc1 || kept1;

      // Loser of a two-way contest gets priority next time.
      if (full0 && full1) prio <= sel0;

      // A fresh req0 entry behind a held req1 entry makes buf1 the elder;
      // same-edge accepts leave req0 as the elder.
      if (kept1 && acc0)         older1 <= 1'b1;
      else if (!(kept0 && kept1)) older1 <= 1'b0;

      state <= (full0 || full1) ? WRITE : IDLE;

      if (sel0 || sel1) begin
        AW       <= sel1 ? addr1 : addr0;
        DW       <= sel1 ? data1 : data0;
        grant_id <= sel1;
      end
    end
  end

  // NOTE: buffer payload needs no reset; it is only observed behind full0/full1,
  // and acceptance is impossible while rst_n is low.
  always_ff @(posedge clk) begin
    if (acc0) begin
      addr0 <= req0_addr;
      data0 <= req0_data;
    end
    if (acc1) begin
      addr1 <= req1_addr;
      data1 <= req1_data;
    end
  end

endmodule

// File: tb/tb_arbitro_escritura_br.sv
`timescale 1ns/1ps
module tb_arbitro_escritura_br;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 req0_valid, req1_valid;
  logic [ADDR_W-1:0]    req0_addr, req1_addr;
  logic [DATA_W-1:0]    req0_data, req1_data;
  logic                 req0_ready, req1_ready;
  logic                 EnW;
  logic [ADDR_W-1:0]    AW;
  logic [DATA_W-1:0]    DW;
  logic [2**ADDR_W-1:0] busy;
  logic                 grant_id;

  arbitro_escritura_br #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .EnW(EnW), .AW(AW), .DW(DW), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  a;
    logic [31:0] d;
    logic        g;
  } wr_t;

  wr_t         log_q[$];
  logic [31:0] bank [32];
  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Register-bank model: records every write seen on the port.
  always @(negedge clk) begin
    if (EnW === 1'b1) begin
      log_q.push_back('{cyc, AW, DW, grant_id});
      bank[AW] <= DW;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int         base;
  int         i0, i1;
  logic       a0, a1;
  logic       rd0 [10];
  logic       rd1 [10];
  logic [4:0] exp_aw [6];
  logic [31:0] exp_dw [6];

  initial begin
    exp_aw = '{5'd1, 5'd10, 5'd2, 5'd11, 5'd3, 5'd12};
    exp_dw = '{32'h100, 32'h200, 32'h101, 32'h201, 32'h102, 32'h202};

    // Reset held with a pending request.
    rst_n      = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hdead;
    req1_valid = 1'b0; req1_addr = '0;   req1_data = '0;
    step(3);
    check("rst_enw",    EnW, 0);
    check("rst_aw",     AW, 0);
    check("rst_dw",     DW, 0);
    check("rst_busy",   busy, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    rst_n = 1'b1; req0_valid = 1'b0;
    #1;
    check("rel_ready0", req0_ready, 1);
    check("rel_ready1", req1_ready, 1);

    // Single write from requester 0.
    base = log_q.size();
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h1234;
    step();
    req0_valid = 1'b0;
    check("single_busy5", busy, 32'h0000_0020);
    check("single_enw0",  EnW, 0);
    step();
    check("single_enw1",  EnW, 1);
    check("single_aw",    AW, 5);
    check("single_dw",    DW, 32'h1234);
    check("single_gid",   grant_id, 0);
    check("single_busy0", busy, 0);
    step();
    check("single_enw_off", EnW, 0);
    check("single_count", log_q.size() - base, 1);

    // Same address, req1 older: req0 {9} and req1 {7,AA} together, then
    // req0 {7,BB} refills behind the held req1 entry.
    base = log_q.size();
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hAA;
    step();
    req0_addr = 5'd7; req0_data = 32'hBB;
    req1_valid = 1'b0;
    check("age_busy",   busy, (32'd1 << 9) | (32'd1 << 7));
    check("age_ready0", req0_ready, 1);
    check("age_ready1", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    check("age_w1_aw", AW, 9);
    check("age_busy7", busy, 32'd1 << 7);
    step();
    check("age_w2_aw",  AW, 7);
    check("age_w2_dw",  DW, 32'hAA);
    check("age_w2_gid", grant_id, 1);
    step();
    check("age_w3_dw",  DW, 32'hBB);
    check("age_w3_gid", grant_id, 0);
    step();
    check("age_enw_off", EnW, 0);
    check("age_bank7",   bank[7], 32'hBB);
    check("age_count",   log_q.size() - base, 3);

    // Both requesters streaming.
    base = log_q.size();
    i0 = 0; i1 = 0;
    for (int c = 0; c < 10; c++) begin
      req0_valid = (i0 < 3); req0_addr = 5'(1 + i0);  req0_data = 32'h100 + i0;
      req1_valid = (i1 < 3); req1_addr = 5'(10 + i1); req1_data = 32'h200 + i1;
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      step();
      i0 += int'(a0);
      i1 += int'(a1);
      rd0[c] = req0_ready;
      rd1[c] = req1_ready;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("cont_count", log_q.size() - base, 6);
    if (log_q.size() - base == 6) begin
      for (int k = 0; k < 6; k++) begin
        check($sformatf("cont_aw%0d", k), log_q[base+k].a, exp_aw[k]);
        check($sformatf("cont_dw%0d", k), log_q[base+k].d, exp_dw[k]);
        check($sformatf("cont_cyc%0d", k), log_q[base+k].cyc - log_q[base].cyc, k);
      end
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("cont_rd0_%0d", k), rd0[k], (k % 2 == 0) ? 1 : 0);
      check($sformatf("cont_rd1_%0d", k), rd1[k], (k % 2 == 0) ? 0 : 1);
    end

    // Same-edge, same-address: req0 must win even though prio favours req1.
    base = log_q.size();
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h22;
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("same_busy4", busy, 32'd1 << 4);
    step();
    check("same_w1_dw",  DW, 32'h11);
    check("same_w1_gid", grant_id, 0);
    step();
    check("same_w2_dw",  DW, 32'h22);
    check("same_w2_gid", grant_id, 1);
    step();
    check("same_enw_off", EnW, 0);
    check("same_bank4",   bank[4], 32'h22);

    // Reset with both buffers full drops both writes.
    req0_valid = 1'b1; req0_addr = 5'd2; req0_data = 32'h1;
    req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'h2;
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("mid_busy_full", busy, 32'h0000_000C);
    rst_n = 1'b0;
    #1;
    check("mid_busy_rst",   busy, 0);
    check("mid_ready0_rst", req0_ready, 0);
    step();
    check("mid_enw",  EnW, 0);
    check("mid_prio", dut.prio, 0);
    rst_n = 1'b1;
    base = log_q.size();
    step(3);
    check("mid_no_write", log_q.size() - base, 0);
    check("mid_busy",     busy, 0);

    // Single req1 write after reset.
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h66;
    step();
    req1_valid = 1'b0;
    check("post_busy6", busy, 32'd1 << 6);
    step();
    check("post_enw", EnW, 1);
    check("post_aw",  AW, 6);
    check("post_dw",  DW, 32'h66);
    check("post_gid", grant_id, 1);
    step();
    check("post_enw_off", EnW, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
